// File: rtl/kb_key_tracker_pkg.sv
// Shared key ids, PS/2 set-2 scan-code constants and prefix FSM encoding
// for the keyboard key tracker.
package kb_pkg;

  localparam int NUM_KEYS = 6;

  localparam logic [2:0] KEY_LEFT  = 3'd0;
  localparam logic [2:0] KEY_RIGHT = 3'd1;
  localparam logic [2:0] KEY_UP    = 3'd2;
  localparam logic [2:0] KEY_DOWN  = 3'd3;
  localparam logic [2:0] KEY_RESET = 3'd4;
  localparam logic [2:0] KEY_ENTER = 3'd5;

  localparam logic [7:0] SC_F0     = 8'hF0;
  localparam logic [7:0] SC_E0     = 8'hE0;
  localparam logic [7:0] SC_A      = 8'h1C;
  localparam logic [7:0] SC_D      = 8'h23;
  localparam logic [7:0] SC_W      = 8'h1D;
  localparam logic [7:0] SC_S      = 8'h1B;
  localparam logic [7:0] SC_R      = 8'h2D;
  localparam logic [7:0] SC_ENTER  = 8'h5A;

  localparam logic [7:0] SC_EXT_LEFT  = 8'h6B;
  localparam logic [7:0] SC_EXT_RIGHT = 8'h74;
  localparam logic [7:0] SC_EXT_UP    = 8'h75;
  localparam logic [7:0] SC_EXT_DOWN  = 8'h72;
  localparam logic [7:0] SC_EXT_ENTER = 8'h5A;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BRK     = 2'd1,
    ST_EXT     = 2'd2,
    ST_EXT_BRK = 2'd3
  } kb_state_e;

endpackage

// File: rtl/kb_key_tracker_if.sv
// Byte stream in from ps2_rx and key state out to the game engine.
// master = byte source / key consumer, slave = the tracker.
interface kb_key_tracker_if;
  import kb_pkg::*;

  logic                scan_done_tick;
  logic [7:0]          scan_code;
  logic [NUM_KEYS-1:0] key_held;
  logic [NUM_KEYS-1:0] key_press;
  logic                prefix_busy;

  modport master (output scan_done_tick, scan_code,
                  input  key_held, key_press, prefix_busy);
  modport slave  (input  scan_done_tick, scan_code,
                  output key_held, key_press, prefix_busy);
endinterface

// File: rtl/kb_key_tracker_key_map.sv
// Scan-code lookup shared by make and break paths: {ext, code} -> {hit, key_id}.
module kb_key_map
  import kb_pkg::*;
(
  input  logic       ext,
  input  logic [7:0] code,
  output logic       hit,
  output logic [2:0] key_id
);
  always_comb begin
    hit    = 1'b1;
    key_id = KEY_LEFT;
    if (ext) begin
      case (code)
        SC_EXT_LEFT:  key_id = KEY_LEFT;
        SC_EXT_RIGHT: key_id = KEY_RIGHT;
        SC_EXT_UP:    key_id = KEY_UP;
        SC_EXT_DOWN:  key_id = KEY_DOWN;
        SC_EXT_ENTER: key_id = KEY_ENTER;
        default:      hit    = 1'b0;
      endcase
    end else begin
      case (code)
        SC_A:     key_id = KEY_LEFT;
        SC_D:     key_id = KEY_RIGHT;
        SC_W:     key_id = KEY_UP;
        SC_S:     key_id = KEY_DOWN;
        SC_R:     key_id = KEY_RESET;
        SC_ENTER: key_id = KEY_ENTER;
        default:  hit    = 1'b0;
      endcase
    end
  end
endmodule

// File: rtl/kb_key_tracker.sv
// PS/2 set-2 make/break decoder for the six game keys: held levels + press pulses.
// Define KB_AUTOREPEAT_EN to build per-key auto-repeat pulse generation.
module kb_key_tracker
  import kb_pkg::*;
#(
`ifdef KB_AUTOREPEAT_EN
  parameter int unsigned REPEAT_DELAY  = 50_000_000,
  parameter int unsigned REPEAT_PERIOD = 10_000_000,
`endif
  parameter int unsigned PREFIX_TIMEOUT = 500_000
) (
  input logic             clk,
  input logic             reset,
  kb_key_tracker_if.slave kbif
);
  localparam logic [NUM_KEYS-1:0] KEY_ONE = NUM_KEYS'(1);

  kb_state_e           state_q, state_d;
  logic [31:0]         to_cnt_q, to_cnt_d;
  logic [NUM_KEYS-1:0] held_q, held_d, press_q, press_d;
  logic [NUM_KEYS-1:0] key_vec, make_vec, brk_vec, rep_fire;
  logic                ext, hit;
  logic [2:0]          key_id;

  assign ext = (state_q == ST_EXT) || (state_q == ST_EXT_BRK);

  kb_key_map u_map (.ext(ext), .code(kbif.scan_code), .hit(hit), .key_id(key_id));

  assign key_vec = hit ? (KEY_ONE << key_id) : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      to_cnt_q <= '0;
      held_q   <= '0;
      press_q  <= '0;
    end else begin
      state_q  <= state_d;
      to_cnt_q <= to_cnt_d;
      held_q   <= held_d;
      press_q  <= press_d;
    end
  end

  // Prefix bytes never hit the map, so only the final byte of a sequence decodes.
  always_comb begin
    state_d  = state_q;
    to_cnt_d = to_cnt_q;
    if (kbif.scan_done_tick) begin
      to_cnt_d = '0;
      case (state_q)
        ST_IDLE: begin
          if (kbif.scan_code == SC_F0)      state_d = ST_BRK;
          else if (kbif.scan_code == SC_E0) state_d = ST_EXT;
        end
        ST_EXT:  state_d = (kbif.scan_code == SC_F0) ? ST_EXT_BRK : ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end else if (state_q != ST_IDLE) begin
      if (to_cnt_q == PREFIX_TIMEOUT - 1) begin
        state_d  = ST_IDLE;
        to_cnt_d = '0;
      end else begin
        to_cnt_d = to_cnt_q + 32'd1;
      end
    end
  end

  always_comb begin
    make_vec = '0;
    brk_vec  = '0;
    if (kbif.scan_done_tick) begin
      if (state_q == ST_IDLE || state_q == ST_EXT) make_vec = key_vec;
      else                                          brk_vec  = key_vec;
    end
    held_d  = (held_q | make_vec) & ~brk_vec;
    press_d = (make_vec & ~held_q) | rep_fire;
  end

`ifdef KB_AUTOREPEAT_EN
  logic [NUM_KEYS-1:0][31:0] rep_cnt_q, rep_cnt_d;

  // Counter restarts at DELAY-PERIOD after each fire so later pulses are PERIOD apart.
  always_comb begin
    for (int k = 0; k < NUM_KEYS; k++) begin
      rep_fire[k]  = 1'b0;
      rep_cnt_d[k] = '0;
      if (held_q[k] && !brk_vec[k]) begin
        if (rep_cnt_q[k] == REPEAT_DELAY - 1) begin
          rep_fire[k]  = 1'b1;
          rep_cnt_d[k] = REPEAT_DELAY - REPEAT_PERIOD;
        end else begin
          rep_cnt_d[k] = rep_cnt_q[k] + 32'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) rep_cnt_q <= '0;
    else       rep_cnt_q <= rep_cnt_d;
  end
`else
  assign rep_fire = '0;
`endif

  assign kbif.key_held    = held_q;
  assign kbif.key_press   = press_q;
  assign kbif.prefix_busy = (state_q != ST_IDLE);
endmodule

// File: tb/tb_kb_key_tracker.sv
// Directed bench for kb_key_tracker: sequence-level reference model checked every
// cycle, plus literal expectations for the documented scenarios.
module tb_kb_key_tracker;
  localparam int PTO    = 16;
  localparam int RDELAY = 100;
  localparam int RPER   = 20;

  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  kb_key_tracker_if kbif ();

`ifdef KB_AUTOREPEAT_EN
  kb_key_tracker #(.REPEAT_DELAY(RDELAY), .REPEAT_PERIOD(RPER), .PREFIX_TIMEOUT(PTO))
    dut (.clk(clk), .reset(reset), .kbif(kbif));
`else
  kb_key_tracker #(.PREFIX_TIMEOUT(PTO)) dut (.clk(clk), .reset(reset), .kbif(kbif));
`endif

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int map_key(input bit e, input logic [7:0] b);
    if (e) case (b)
      8'h6B: return 0; 8'h74: return 1; 8'h75: return 2;
      8'h72: return 3; 8'h5A: return 5; default: return -1;
    endcase
    case (b)
      8'h1C: return 0; 8'h23: return 1; 8'h1D: return 2;
      8'h1B: return 3; 8'h2D: return 4; 8'h5A: return 5; default: return -1;
    endcase
  endfunction

  // Reference model: pending-prefix flags, idle time since last byte, per-key hold age.
  bit         m_brk, m_ext;
  int         m_idle;
  logic [5:0] m_held, m_press;
  int         m_age [6];

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_brk <= 0; m_ext <= 0; m_idle <= 0; m_held <= '0; m_press <= '0;
      for (int i = 0; i < 6; i++) m_age[i] <= 0;
    end else begin
      automatic bit         brk   = m_brk;
      automatic bit         ext   = m_ext;
      automatic int         idle  = m_idle;
      automatic logic [5:0] held  = m_held;
      automatic logic [5:0] press = '0;
      automatic int         k     = -1;
      automatic bit         mk    = 0;
      if (kbif.scan_done_tick) begin
        automatic logic [7:0] b = kbif.scan_code;
        idle = 0;
        if (brk) begin
          k = map_key(ext, b); brk = 0; ext = 0;
        end else if (ext) begin
          if (b == 8'hF0) brk = 1;
          else begin k = map_key(1, b); mk = 1; ext = 0; end
        end else if (b == 8'hF0) brk = 1;
        else if (b == 8'hE0) ext = 1;
        else begin k = map_key(0, b); mk = 1; end
        if (k >= 0) begin
          if (mk) begin
            if (!held[k]) press[k] = 1'b1;
            held[k] = 1'b1;
          end else held[k] = 1'b0;
        end
      end else if (brk || ext) begin
        idle++;
        if (idle == PTO) begin brk = 0; ext = 0; idle = 0; end
      end
      for (int i = 0; i < 6; i++) begin
        automatic int a = 0;
        if (held[i] && m_held[i]) begin
          a = m_age[i] + 1;
`ifdef KB_AUTOREPEAT_EN
          if (a >= RDELAY && (a - RDELAY) % RPER == 0) press[i] = 1'b1;
`endif
        end
        m_age[i] <= a;
      end
      m_brk <= brk; m_ext <= ext; m_idle <= idle; m_held <= held; m_press <= press;
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      chk("model_held",  32'(kbif.key_held),    32'(m_held));
      chk("model_press", 32'(kbif.key_press),   32'(m_press));
      chk("model_busy",  32'(kbif.prefix_busy), 32'(m_brk | m_ext));
    end
  end

  task automatic send(input logic [7:0] b);
    kbif.scan_done_tick = 1'b1;
    kbif.scan_code      = b;
    @(negedge clk);
    kbif.scan_done_tick = 1'b0;
    kbif.scan_code      = 8'h00;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  int pulses [$];
  int exp_pulses [$];

  initial begin
    reset = 1'b1;
    kbif.scan_done_tick = 1'b0;
    kbif.scan_code      = 8'h00;
    idle(2);
    chk("rst_held",  32'(kbif.key_held),    32'h0);
    chk("rst_press", 32'(kbif.key_press),   32'h0);
    chk("rst_busy",  32'(kbif.prefix_busy), 32'h0);
    reset = 1'b0;
    idle(1);

    // plain make then break
    send(8'h1C);
    chk("t1_held",  32'(kbif.key_held),  32'h01);
    chk("t1_press", 32'(kbif.key_press), 32'h01);
    idle(1);
    chk("t1_press_once", 32'(kbif.key_press), 32'h00);
    send(8'hF0);
    chk("t1_busy", 32'(kbif.prefix_busy), 32'h1);
    send(8'h1C);
    chk("t1_release", 32'(kbif.key_held), 32'h00);
    chk("t1_brk_nopulse", 32'(kbif.key_press), 32'h00);
    idle(2);

    // typematic resend gives a single press
    send(8'h1D);
    chk("t2_press", 32'(kbif.key_press), 32'h04);
    for (int i = 0; i < 4; i++) begin
      idle(3);
      send(8'h1D);
      chk("t2_resend", 32'(kbif.key_press), 32'h00);
    end
    chk("t2_held", 32'(kbif.key_held), 32'h04);
    send(8'hF0); send(8'h1D);
    chk("t2_release", 32'(kbif.key_held), 32'h00);
    idle(2);

    // extended codes
    send(8'hE0); send(8'h6B);
    chk("t3_held",  32'(kbif.key_held),  32'h01);
    chk("t3_press", 32'(kbif.key_press), 32'h01);
    send(8'hE0); send(8'hF0);
    chk("t3_busy", 32'(kbif.prefix_busy), 32'h1);
    send(8'h6B);
    chk("t3_release", 32'(kbif.key_held), 32'h00);
    send(8'hE0); send(8'h12);
    chk("t3_unmapped", 32'(kbif.key_held),    32'h00);
    chk("t3_idle",     32'(kbif.prefix_busy), 32'h0);
    send(8'hAA);
    chk("t3_reply", 32'(kbif.key_held), 32'h00);
    idle(2);

    // prefix timeout
    send(8'hF0);
    idle(PTO - 1);
    chk("t4_still_busy", 32'(kbif.prefix_busy), 32'h1);
    idle(1);
    chk("t4_timeout", 32'(kbif.prefix_busy), 32'h0);
    send(8'h23);
    chk("t4_press", 32'(kbif.key_press), 32'h02);
    chk("t4_held",  32'(kbif.key_held),  32'h02);
    send(8'hF0); send(8'h23);
    idle(2);

    // reset mid-sequence
    send(8'h5A);
    chk("t5_held", 32'(kbif.key_held), 32'h20);
    send(8'hE0);
    reset = 1'b1;
    idle(1);
    chk("t5_rst_held",  32'(kbif.key_held),    32'h0);
    chk("t5_rst_press", 32'(kbif.key_press),   32'h0);
    chk("t5_rst_busy",  32'(kbif.prefix_busy), 32'h0);
    reset = 1'b0;
    idle(1);
    send(8'h5A);
    chk("t5_repress", 32'(kbif.key_press), 32'h20);
    send(8'hF0); send(8'h5A);
    idle(2);

    // hold DOWN for 200 cycles and record press pulse times
    send(8'h1B);
    if (kbif.key_press[3]) pulses.push_back(1);
    for (int t = 2; t <= 200; t++) begin
      @(negedge clk);
      if (kbif.key_press[3]) pulses.push_back(t);
    end
`ifdef KB_AUTOREPEAT_EN
    exp_pulses = '{1, 101, 121, 141, 161, 181};
`else
    exp_pulses = '{1};
`endif
    chk("t6_pulse_count", 32'(pulses.size()), 32'(exp_pulses.size()));
    for (int i = 0; i < exp_pulses.size() && i < pulses.size(); i++)
      chk("t6_pulse_time", 32'(pulses[i]), 32'(exp_pulses[i]));
    send(8'hF0); send(8'h1B);
    chk("t6_release", 32'(kbif.key_held), 32'h00);
    idle(3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
